// File: rtl/result_uart_tx.sv
// Queues 64-bit result records from the processor top and streams each one over a
// UART 8N1 line as a sync byte followed by the eight record bytes, MSB first.
module result_uart_tx #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [63:0]                   data,
    input  logic                          enable,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0]   FULL_COUNT = FIFO_DEPTH[AW:0];
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          enable_q;
    logic [63:0]   last_rec;
    logic [71:0]   shreg, shreg_n;
    logic [7:0]    cur_byte;
    logic [3:0]    byte_idx, byte_idx_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [BW-1:0] baud, baud_n;
    logic          push, pop, full, accept, baud_done;

    // enable is a level: a record is new on a rising enable or a changed value
    assign push      = enable & (~enable_q | (data != last_rec));
    assign full      = (count == FULL_COUNT);
    assign pop       = (state == IDLE) & (count != '0);
    assign accept    = push & (~full | pop);
    assign baud_done = (baud == BAUD_LAST);
    assign cur_byte  = shreg[71:64];

    always_ff @(posedge clk) begin
        if (!reset) begin
            enable_q <= 1'b0;
            last_rec <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            enable_q <= enable;
            if (push)
                last_rec <= data;
            if (accept) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop)
                overflow <= 1'b1;
            if (accept && !pop)
                count <= count + 1'b1;
            else if (!accept && pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            shreg    <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            baud     <= '0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            byte_idx <= byte_idx_n;
            bit_idx  <= bit_idx_n;
            baud     <= baud_n;
        end
    end

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        byte_idx_n = byte_idx;
        bit_idx_n  = bit_idx;
        baud_n     = baud;
        tx         = 1'b1;
        case (state)
            IDLE: begin
                baud_n = '0;
                if (pop) begin
                    shreg_n    = {SYNC_BYTE, mem[rd_ptr]};
                    byte_idx_n = '0;
                    state_n    = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (baud_done) begin
                    baud_n    = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            DATA: begin
                tx = cur_byte[bit_idx];
                if (baud_done) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7)
                        state_n = STOP;
                    else
                        bit_idx_n = bit_idx + 1'b1;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_n = '0;
                    // bytes follow each other with no idle gap inside one record
                    if (byte_idx < 4'd8) begin
                        byte_idx_n = byte_idx + 1'b1;
                        shreg_n    = {shreg[63:0], 8'h00};
                        state_n    = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy       = (state != IDLE) | (count != '0);
    assign fifo_count = count;

endmodule
